// File: rtl/crypt_pkg.sv
// Shared constants and helpers for the byte encryption/decryption pair.
// Holds the key parts, the forward/inverse 8-bit permutation and the
// decryption stage state encoding.
package crypt_pkg;

  localparam logic [7:0] K1  = 8'h3E;
  localparam logic [7:0] K2  = 8'h49;
  localparam logic [7:0] K3  = 8'h7E;
  localparam logic [7:0] KEY = K1 ^ K2 ^ K3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    FULL   = 2'b10
  } dec_state_e;

  // Forward bit permutation applied by the encryption block before the key XOR.
  function automatic logic [7:0] perm(input logic [7:0] b);
    return {b[0], b[5], b[2], b[6], b[7], b[4], b[3], b[1]};
  endfunction

  // Inverse of perm: unperm(perm(b)) == b for every byte.
  function automatic logic [7:0] unperm(input logic [7:0] p);
    return {p[3], p[4], p[6], p[2], p[1], p[5], p[0], p[7]};
  endfunction

endpackage

// File: rtl/decryption_fifo.sv
// Plaintext buffer for decryption_stage: storage, wrapping pointers,
// occupancy counter and a registered head word that is valid one cycle
// after a byte lands in an empty buffer.
module decryption_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [N-1:0]               wdata,
  output logic [N-1:0]               head,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     level_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};

  logic [N-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic [LW-1:0] remain_s;
  logic [N-1:0]  head_r;
  logic [N-1:0]  head_nxt_s;

  // Next pointer, next occupancy and next head word (bypass when the buffer would be empty).
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    head_nxt_s   = head_r;
    remain_s     = level_r - {{(LW-1){1'b0}}, pop};
    if (pop) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push, pop})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
    if (push && (remain_s == LVL_ZERO)) begin
      head_nxt_s = wdata;
    end else if (remain_s != LVL_ZERO) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Storage array; contents need no reset since only occupied slots are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= LVL_ZERO;
      head_r   <= {N{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      head_r   <= head_nxt_s;
    end
  end

  assign head      = head_r;
  assign level     = level_r;
  assign level_nxt = level_nxt_s;

endmodule

// File: rtl/decryption_stage.sv
// Decryption stage: undoes the key XOR and bit permutation of the byte
// encryption block, buffers plaintext in a small FIFO and presents it with
// valid/ready. Drops and flags (sticky ovf) bytes arriving while full.
// Optional build macro DECRYPTION_STATS_EN adds a saturating pop counter stat_cnt.
module decryption_stage
  import crypt_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [N-1:0]           din,
  input  logic                   din_v,
  output logic [N-1:0]           dout,
  output logic                   dout_v,
  input  logic                   dout_rdy,
  output logic                   in_rdy,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
`ifdef DECRYPTION_STATS_EN
  ,
  output logic [15:0]            stat_cnt
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};

  if (N != 8) begin : g_bad_width
    $error("decryption_stage: N must be 8");
  end
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("decryption_stage: DEPTH must be a power of two in 2..16");
  end

  dec_state_e    state_r;
  dec_state_e    state_nxt_s;
  logic [7:0]    plain_s;
  logic          push_s;
  logic          pop_s;
  logic [LW-1:0] level_s;
  logic [LW-1:0] level_nxt_s;
  logic          dout_v_r;
  logic          in_rdy_r;
  logic          ovf_r;

  // Decode the incoming ciphertext byte and qualify the push/pop strobes.
  always_comb begin
    plain_s = unperm(din ^ KEY);
    pop_s   = dout_v_r && dout_rdy;
    push_s  = din_v && ((level_s != LVL_FULL) || pop_s);
  end

  decryption_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .wdata     (plain_s),
    .head      (dout),
    .level     (level_s),
    .level_nxt (level_nxt_s)
  );

  // Next state follows the occupancy the FIFO will hold after this edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (push_s) state_nxt_s = STREAM;
        else        state_nxt_s = IDLE;
      end
      STREAM: begin
        if (level_nxt_s == LVL_FULL)      state_nxt_s = FULL;
        else if (level_nxt_s == LVL_ZERO) state_nxt_s = IDLE;
        else                              state_nxt_s = STREAM;
      end
      FULL: begin
        if (level_nxt_s != LVL_FULL) state_nxt_s = STREAM;
        else                         state_nxt_s = FULL;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered valid/ready flags and sticky overflow.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      dout_v_r <= 1'b0;
      in_rdy_r <= 1'b1;
      ovf_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      dout_v_r <= (state_nxt_s != IDLE);
      in_rdy_r <= (state_nxt_s != FULL);
      if (din_v && !push_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign dout_v = dout_v_r;
  assign in_rdy = in_rdy_r;
  assign ovf    = ovf_r;
  assign level  = level_s;

`ifdef DECRYPTION_STATS_EN
  logic [15:0] stat_cnt_r;

  // Count popped bytes, holding at the top value.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      stat_cnt_r <= 16'h0000;
    end else if (pop_s && (stat_cnt_r != 16'hFFFF)) begin
      stat_cnt_r <= stat_cnt_r + 16'h0001;
    end
  end

  assign stat_cnt = stat_cnt_r;
`endif

endmodule

// File: tb/tb_decryption_stage.sv
// Directed bench for decryption_stage: decode table, streaming, overflow,
// full push+pop, 256-byte loopback and asynchronous reset mid-stream.
module tb_decryption_stage;

  logic       clock;
  logic       rst;
  logic [7:0] din;
  logic       din_v;
  logic [7:0] dout;
  logic       dout_v;
  logic       dout_rdy;
  logic       in_rdy;
  logic       ovf;
  logic [2:0] level;
`ifdef DECRYPTION_STATS_EN
  logic [15:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] cipher;
    logic [7:0] plain;
  } vec_t;

  vec_t vecs [8];

  decryption_stage #(.N(8), .DEPTH(4)) dut (
    .clock    (clock),
    .rst      (rst),
    .din      (din),
    .din_v    (din_v),
    .dout     (dout),
    .dout_v   (dout_v),
    .dout_rdy (dout_rdy),
    .in_rdy   (in_rdy),
    .ovf      (ovf),
    .level    (level)
`ifdef DECRYPTION_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent model of the encryption block: route each bit, then XOR key 0x09.
  function automatic logic [7:0] encrypt(input logic [7:0] x);
    logic [7:0] q;
    q[3] = x[7]; q[4] = x[6]; q[6] = x[5]; q[2] = x[4];
    q[1] = x[3]; q[5] = x[2]; q[0] = x[1]; q[7] = x[0];
    return q ^ 8'h09;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; din_v = 1'b0; dout_rdy = 1'b0; din = 8'h00;
    #2;
    chk("rst_dout", {24'h0, dout}, 32'h00);
    chk("rst_dout_v", {31'h0, dout_v}, 32'h0);
    chk("rst_level", {29'h0, level}, 32'h0);
    chk("rst_in_rdy", {31'h0, in_rdy}, 32'h1);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    #10;
    rst = 1'b1;
    step();
  endtask

  initial begin
    vecs[0] = '{8'h89, 8'h01};
    vecs[1] = '{8'h09, 8'h00};
    vecs[2] = '{8'hF6, 8'hFF};
    vecs[3] = '{8'h01, 8'h80};
    vecs[4] = '{8'h08, 8'h02};
    vecs[5] = '{8'h0D, 8'h10};
    vecs[6] = '{8'h49, 8'h20};
    vecs[7] = '{8'h29, 8'h04};

    rst = 1'b1; din = 8'h00; din_v = 1'b0; dout_rdy = 1'b0;
    #1;
    do_reset();

    // Single-byte transactions from the table: one-cycle latency then empty again.
    for (int i = 0; i < 8; i++) begin
      din = vecs[i].cipher; din_v = 1'b1; dout_rdy = 1'b1;
      step();
      chk("single_dout", {24'h0, dout}, {24'h0, vecs[i].plain});
      chk("single_v", {31'h0, dout_v}, 32'h1);
      chk("single_level", {29'h0, level}, 32'h1);
      din_v = 1'b0;
      step();
      chk("single_drain_v", {31'h0, dout_v}, 32'h0);
      chk("single_drain_level", {29'h0, level}, 32'h0);
    end

    // Back-to-back stream with the sink always ready.
    dout_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = vecs[i].cipher; din_v = 1'b1;
      step();
      chk("stream_dout", {24'h0, dout}, {24'h0, vecs[i].plain});
      chk("stream_v", {31'h0, dout_v}, 32'h1);
    end
    din_v = 1'b0;
    step();
    chk("stream_end_v", {31'h0, dout_v}, 32'h0);

    // Overflow: five pushes into a four-entry buffer with the sink stalled.
    dout_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = vecs[i].cipher; din_v = 1'b1;
      step();
      if (i == 3) begin
        chk("ovf_level4", {29'h0, level}, 32'h4);
        chk("ovf_in_rdy0", {31'h0, in_rdy}, 32'h0);
        chk("ovf_not_yet", {31'h0, ovf}, 32'h0);
        chk("ovf_head_stable", {24'h0, dout}, {24'h0, vecs[0].plain});
      end
    end
    din_v = 1'b0;
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    chk("ovf_level_held", {29'h0, level}, 32'h4);
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_dout", {24'h0, dout}, {24'h0, vecs[i].plain});
      chk("ovf_drain_v", {31'h0, dout_v}, 32'h1);
      step();
    end
    chk("ovf_drained_v", {31'h0, dout_v}, 32'h0);
    chk("ovf_drained_in_rdy", {31'h0, in_rdy}, 32'h1);
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);

    // Full buffer: simultaneous push and pop keeps level and order, no overflow.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din = vecs[i].cipher; din_v = 1'b1;
      step();
    end
    chk("full_level", {29'h0, level}, 32'h4);
    din = vecs[4].cipher; din_v = 1'b1; dout_rdy = 1'b1;
    chk("full_head", {24'h0, dout}, {24'h0, vecs[0].plain});
    step();
    din_v = 1'b0;
    chk("pp_level", {29'h0, level}, 32'h4);
    chk("pp_ovf", {31'h0, ovf}, 32'h0);
    for (int i = 1; i < 5; i++) begin
      chk("pp_order", {24'h0, dout}, {24'h0, vecs[i].plain});
      step();
    end
    chk("pp_empty_v", {31'h0, dout_v}, 32'h0);
    chk("pp_ovf_end", {31'h0, ovf}, 32'h0);
`ifdef DECRYPTION_STATS_EN
    chk("stat_count5", {16'h0, stat_cnt}, 32'd5);
`endif

    // Asynchronous reset with three bytes buffered.
    dout_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = vecs[i + 5].cipher; din_v = 1'b1;
      step();
    end
    din_v = 1'b0;
    chk("arst_pre_level", {29'h0, level}, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_v", {31'h0, dout_v}, 32'h0);
    chk("arst_level", {29'h0, level}, 32'h0);
    chk("arst_in_rdy", {31'h0, in_rdy}, 32'h1);
`ifdef DECRYPTION_STATS_EN
    chk("arst_stat", {16'h0, stat_cnt}, 32'd0);
`endif
    din = vecs[2].cipher; din_v = 1'b1; dout_rdy = 1'b1;
    #4;
    rst = 1'b1;
    step();
    chk("post_rst_dout", {24'h0, dout}, {24'h0, vecs[2].plain});
    chk("post_rst_level", {29'h0, level}, 32'h1);
    din_v = 1'b0;
    step();
    chk("post_rst_empty", {31'h0, dout_v}, 32'h0);

    // Loopback of every plaintext through the encryption model.
    dout_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      din = encrypt(8'(i)); din_v = 1'b1;
      step();
      chk("loop_dout", {24'h0, dout}, i);
      chk("loop_v", {31'h0, dout_v}, 32'h1);
    end
    din_v = 1'b0;
    step();
    chk("loop_end_level", {29'h0, level}, 32'h0);
    chk("loop_ovf", {31'h0, ovf}, 32'h0);
`ifdef DECRYPTION_STATS_EN
    chk("loop_stat", {16'h0, stat_cnt}, 32'd257);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
